// File: rtl/vga_test_pattern_gen.sv
// ---------------------------------------------------------------------------
// vga_test_pattern_gen
//
// Purpose
//   Free-running VGA raster timing generator with a small set of built-in
//   test patterns (black, white, quadrants, colour bars, checkerboard,
//   border). The requested pattern is sampled once per frame, on the last
//   pixel of the raster, so a pattern change never tears a frame.
//
// Optional feature (compile-time macro)
//   VGA_TPG_SCROLL_EN - adds a horizontal scroll offset that advances by one
//                       pixel per frame. The colour bars and checkerboard are
//                       drawn at x = (col + offset) mod ACTIVE_COLS. Without
//                       the macro no offset register exists and x = col.
//
// Ports
//   i_Clk          in   1            pixel clock, rising edge
//   i_Rst_L        in   1            asynchronous active-low reset
//   i_Pattern      in   3            requested pattern code (0..7)
//   o_HSync        out  1            horizontal sync, active-low, registered
//   o_VSync        out  1            vertical sync, active-low, registered
//   o_Red_Video    out  VIDEO_WIDTH  red channel, registered
//   o_Grn_Video    out  VIDEO_WIDTH  green channel, registered
//   o_Blu_Video    out  VIDEO_WIDTH  blue channel, registered
//   o_Col_Count    out  10           live (unregistered) column counter
//   o_Row_Count    out  10           live (unregistered) row counter
//   o_Frame_Start  out  1            one-cycle pulse when the registered
//                                    outputs show pixel (0,0)
//
// Timing
//   Syncs, video and o_Frame_Start carry one cycle of latency relative to
//   o_Col_Count / o_Row_Count: they describe the pixel the counters held on
//   the previous cycle.
// ---------------------------------------------------------------------------
`default_nettype none

module vga_test_pattern_gen #(
  parameter int VIDEO_WIDTH   = 3,
  parameter int TOTAL_COLS    = 800,
  parameter int TOTAL_ROWS    = 525,
  parameter int ACTIVE_COLS   = 640,
  parameter int ACTIVE_ROWS   = 480,
  parameter int FRONT_PORCH_H = 16,
  parameter int BACK_PORCH_H  = 48,
  parameter int FRONT_PORCH_V = 10,
  parameter int BACK_PORCH_V  = 33
) (
  input  logic                   i_Clk,
  input  logic                   i_Rst_L,
  input  logic [2:0]             i_Pattern,
  output logic                   o_HSync,
  output logic                   o_VSync,
  output logic [VIDEO_WIDTH-1:0] o_Red_Video,
  output logic [VIDEO_WIDTH-1:0] o_Grn_Video,
  output logic [VIDEO_WIDTH-1:0] o_Blu_Video,
  output logic [9:0]             o_Col_Count,
  output logic [9:0]             o_Row_Count,
  output logic                   o_Frame_Start
);

  // Sync pulse widths are whatever is left of the line/frame after the
  // active region and both porches.
  localparam int SYNC_H = TOTAL_COLS - ACTIVE_COLS - FRONT_PORCH_H - BACK_PORCH_H;
  localparam int SYNC_V = TOTAL_ROWS - ACTIVE_ROWS - FRONT_PORCH_V - BACK_PORCH_V;

  localparam logic [9:0] COL_LAST    = 10'(TOTAL_COLS - 1);
  localparam logic [9:0] ROW_LAST    = 10'(TOTAL_ROWS - 1);
  localparam logic [9:0] ACT_COLS    = 10'(ACTIVE_COLS);
  localparam logic [9:0] ACT_ROWS    = 10'(ACTIVE_ROWS);
  localparam logic [9:0] ACT_COL_END = 10'(ACTIVE_COLS - 1);
  localparam logic [9:0] ACT_ROW_END = 10'(ACTIVE_ROWS - 1);
  localparam logic [9:0] HALF_COLS   = 10'(ACTIVE_COLS / 2);
  localparam logic [9:0] HALF_ROWS   = 10'(ACTIVE_ROWS / 2);

  localparam logic [9:0] HS_FIRST = 10'(ACTIVE_COLS + FRONT_PORCH_H);
  localparam logic [9:0] HS_LAST  = 10'(ACTIVE_COLS + FRONT_PORCH_H + SYNC_H - 1);
  localparam logic [9:0] VS_FIRST = 10'(ACTIVE_ROWS + FRONT_PORCH_V);
  localparam logic [9:0] VS_LAST  = 10'(ACTIVE_ROWS + FRONT_PORCH_V + SYNC_V - 1);

  // Colour-bar divisor, widened so x*8 cannot overflow for x < 1024.
  localparam logic [12:0] BAR_DIV = 13'(ACTIVE_COLS);

  localparam logic [VIDEO_WIDTH-1:0] ONES = {VIDEO_WIDTH{1'b1}};

  // -------------------------------------------------------------------------
  // Raster counters and per-frame state
  // -------------------------------------------------------------------------
  logic [9:0] col_q, col_d;
  logic [9:0] row_q, row_d;
  logic [2:0] pattern_q, pattern_d;
  logic       frame_last;

  // The last pixel of the raster is the only point where the pattern (and
  // the scroll offset) may change; this keeps every frame self-consistent.
  assign frame_last = (col_q == COL_LAST) && (row_q == ROW_LAST);

  always_comb begin
    col_d     = col_q;
    row_d     = row_q;
    pattern_d = pattern_q;

    if (col_q == COL_LAST) begin
      col_d = '0;
      if (row_q == ROW_LAST) begin
        row_d = '0;
      end else begin
        row_d = row_q + 10'd1;
      end
    end else begin
      col_d = col_q + 10'd1;
    end

    if (frame_last) begin
      pattern_d = i_Pattern;
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      col_q     <= '0;
      row_q     <= '0;
      pattern_q <= '0;
    end else begin
      col_q     <= col_d;
      row_q     <= row_d;
      pattern_q <= pattern_d;
    end
  end

  // -------------------------------------------------------------------------
  // Pattern x coordinate
  // -------------------------------------------------------------------------
  logic [9:0] x;

`ifdef VGA_TPG_SCROLL_EN
  logic [9:0]  offset_q, offset_d;
  logic [10:0] x_sum;

  always_comb begin
    offset_d = offset_q;
    if (frame_last) begin
      offset_d = (offset_q == ACT_COL_END) ? '0 : offset_q + 10'd1;
    end
  end

  // Both col (inside the active area) and offset are below ACTIVE_COLS, so
  // a single conditional subtract implements the modulo. Outside the active
  // area x is don't-care because video is blanked.
  always_comb begin
    x_sum = {1'b0, col_q} + {1'b0, offset_q};
    if (x_sum >= {1'b0, ACT_COLS}) begin
      x = 10'(x_sum - {1'b0, ACT_COLS});
    end else begin
      x = x_sum[9:0];
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      offset_q <= '0;
    end else begin
      offset_q <= offset_d;
    end
  end
`else
  assign x = col_q;
`endif

  // -------------------------------------------------------------------------
  // Next-cycle output values, derived from the current counters
  // -------------------------------------------------------------------------
  logic                   hsync_d, vsync_d, frame_start_d;
  logic [VIDEO_WIDTH-1:0] red_d, grn_d, blu_d;
  logic                   active;
  logic                   border;
  logic [12:0]            x_times8;
  logic [2:0]             bar;

  assign active   = (col_q < ACT_COLS) && (row_q < ACT_ROWS);
  assign border   = (col_q == 10'd0) || (col_q == ACT_COL_END) ||
                    (row_q == 10'd0) || (row_q == ACT_ROW_END);
  assign x_times8 = {x, 3'b000};
  // Bar index 0..7 across the active width; the divisor is a constant.
  assign bar      = 3'(x_times8 / BAR_DIV);

  always_comb begin
    hsync_d       = !((col_q >= HS_FIRST) && (col_q <= HS_LAST));
    vsync_d       = !((row_q >= VS_FIRST) && (row_q <= VS_LAST));
    frame_start_d = (col_q == 10'd0) && (row_q == 10'd0);
    red_d         = '0;
    grn_d         = '0;
    blu_d         = '0;

    if (active) begin
      case (pattern_q)
        3'd1: begin
          red_d = ONES;
          grn_d = ONES;
          blu_d = ONES;
        end
        3'd2: begin
          red_d = ONES;
          if (col_q < HALF_COLS) grn_d = ONES;
          if (row_q < HALF_ROWS) blu_d = ONES;
        end
        3'd3: begin
          red_d = {VIDEO_WIDTH{bar[2]}};
          grn_d = {VIDEO_WIDTH{bar[1]}};
          blu_d = {VIDEO_WIDTH{bar[0]}};
        end
        3'd4: begin
          // 32x32 squares: bit 5 flips every 32 pixels / lines.
          if (x[5] ^ row_q[5]) begin
            red_d = ONES;
            grn_d = ONES;
            blu_d = ONES;
          end
        end
        3'd5: begin
          if (border) begin
            red_d = ONES;
            grn_d = ONES;
            blu_d = ONES;
          end
        end
        default: begin
          // 0, 6 and 7 are black
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Output registers (one cycle behind the counters)
  // -------------------------------------------------------------------------
  logic                   hsync_q, vsync_q, frame_start_q;
  logic [VIDEO_WIDTH-1:0] red_q, grn_q, blu_q;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      frame_start_q <= 1'b0;
      red_q         <= '0;
      grn_q         <= '0;
      blu_q         <= '0;
    end else begin
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      frame_start_q <= frame_start_d;
      red_q         <= red_d;
      grn_q         <= grn_d;
      blu_q         <= blu_d;
    end
  end

  assign o_HSync       = hsync_q;
  assign o_VSync       = vsync_q;
  assign o_Frame_Start = frame_start_q;
  assign o_Red_Video   = red_q;
  assign o_Grn_Video   = grn_q;
  assign o_Blu_Video   = blu_q;
  assign o_Col_Count   = col_q;
  assign o_Row_Count   = row_q;

endmodule

`default_nettype wire

// File: tb/tb_vga_test_pattern_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_test_pattern_gen
//
// Runs the pattern generator with a reduced raster (100x70 total, 80x64
// active) so several whole frames fit in a short run. i_Pattern is
// randomised every cycle; on the cycle that feeds the frame-latch edge a
// scheduled value is driven so each pattern gets a full frame. Every cycle
// the outputs are compared against a reference model that works from the
// elapsed cycle count with plain integer arithmetic. A mid-frame
// asynchronous reset is applied partway through.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_vga_test_pattern_gen;

  localparam int VW    = 3;
  localparam int TC    = 100;
  localparam int TR    = 70;
  localparam int AC    = 80;
  localparam int AR    = 64;
  localparam int FPH   = 4;
  localparam int BPH   = 6;
  localparam int FPV   = 2;
  localparam int BPV   = 2;
  localparam int SYNCH = TC - AC - FPH - BPH;
  localparam int SYNCV = TR - AR - FPV - BPV;
  localparam int FRAME = TC * TR;
  localparam int MAXV  = (1 << VW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [2:0]    pat;
  logic          hs, vs, fs;
  logic [VW-1:0] red, grn, blu;
  logic [9:0]    col_cnt, row_cnt;

  vga_test_pattern_gen #(
    .VIDEO_WIDTH  (VW),
    .TOTAL_COLS   (TC),
    .TOTAL_ROWS   (TR),
    .ACTIVE_COLS  (AC),
    .ACTIVE_ROWS  (AR),
    .FRONT_PORCH_H(FPH),
    .BACK_PORCH_H (BPH),
    .FRONT_PORCH_V(FPV),
    .BACK_PORCH_V (BPV)
  ) dut (
    .i_Clk        (clk),
    .i_Rst_L      (rst_n),
    .i_Pattern    (pat),
    .o_HSync      (hs),
    .o_VSync      (vs),
    .o_Red_Video  (red),
    .o_Grn_Video  (grn),
    .o_Blu_Video  (blu),
    .o_Col_Count  (col_cnt),
    .o_Row_Count  (row_cnt),
    .o_Frame_Start(fs)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: n = raster position held by the counters before the next
  // edge (cycles since reset release), fp = pattern of the frame being
  // drawn, off = scroll offset of that frame.
  int n;
  int fp;
  int off;
  int latch_idx;
  int sched [8] = '{2, 3, 4, 5, 1, 6, 3, 0};

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int exp_hs(input int col);
    return (col >= AC + FPH && col < AC + FPH + SYNCH) ? 0 : 1;
  endfunction

  function automatic int exp_vs(input int row);
    return (row >= AR + FPV && row < AR + FPV + SYNCV) ? 0 : 1;
  endfunction

  // Expected colour packed as r*2^(2VW) + g*2^VW + b.
  function automatic int exp_rgb(input int p, input int col, input int row, input int offset);
    int r, g, b, x, bar;
    r = 0; g = 0; b = 0;
    if (col < AC && row < AR) begin
      x = (col + offset) % AC;
      case (p)
        1: begin r = MAXV; g = MAXV; b = MAXV; end
        2: begin
          r = MAXV;
          g = (col < AC / 2) ? MAXV : 0;
          b = (row < AR / 2) ? MAXV : 0;
        end
        3: begin
          bar = (x * 8) / AC;
          r = ((bar / 4) % 2) * MAXV;
          g = ((bar / 2) % 2) * MAXV;
          b = (bar % 2) * MAXV;
        end
        4: begin
          if (((x / 32) % 2) != ((row / 32) % 2)) begin
            r = MAXV; g = MAXV; b = MAXV;
          end
        end
        5: begin
          if (col == 0 || col == AC - 1 || row == 0 || row == AR - 1) begin
            r = MAXV; g = MAXV; b = MAXV;
          end
        end
        default: ;
      endcase
    end
    return (r << (2 * VW)) + (g << VW) + b;
  endfunction

  task automatic check_reset(input string tag);
    chk_eq({tag, "_hsync"}, 32'(hs), 32'd1);
    chk_eq({tag, "_vsync"}, 32'(vs), 32'd1);
    chk_eq({tag, "_rgb"}, 32'({red, grn, blu}), 32'd0);
    chk_eq({tag, "_frame_start"}, 32'(fs), 32'd0);
    chk_eq({tag, "_col"}, 32'(col_cnt), 32'd0);
    chk_eq({tag, "_row"}, 32'(row_cnt), 32'd0);
  endtask

  task automatic run_cycles(input int cnt);
    int col, row;
    logic [2:0] applied;
    for (int i = 0; i < cnt; i++) begin
      applied = pat;
      @(posedge clk);
      #1;
      col = n % TC;
      row = (n / TC) % TR;
      chk_eq("hsync", 32'(hs), 32'(exp_hs(col)));
      chk_eq("vsync", 32'(vs), 32'(exp_vs(row)));
      chk_eq("rgb", 32'({red, grn, blu}), 32'(exp_rgb(fp, col, row, off)));
      chk_eq("frame_start", 32'(fs), 32'(col == 0 && row == 0));
      if (n % FRAME == FRAME - 1) begin
        fp = int'(applied);
`ifdef VGA_TPG_SCROLL_EN
        off = (off + 1) % AC;
`endif
      end
      n++;
      chk_eq("col_count", 32'(col_cnt), 32'(n % TC));
      chk_eq("row_count", 32'(row_cnt), 32'((n / TC) % TR));
      if (n % FRAME == FRAME - 1) begin
        pat = 3'(sched[latch_idx % 8]);
        latch_idx++;
      end else begin
        pat = 3'($urandom_range(0, 7));
      end
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    pat       = 3'($urandom_range(1, 7));
    n         = 0;
    fp        = 0;
    off       = 0;
    latch_idx = 0;

    repeat (3) @(posedge clk);
    #1;
    check_reset("por");
    @(negedge clk);
    rst_n = 1'b1;

    // Six whole frames (black, then scheduled patterns) plus part of a
    // seventh, with random pattern churn mid-frame.
    run_cycles(6 * FRAME + int'($urandom_range(1000, 5000)));

    // Asynchronous reset mid-frame: outputs must clear before any edge.
    #2;
    rst_n = 1'b0;
    pat   = 3'($urandom_range(1, 7));
    #1;
    check_reset("async_rst");
    repeat (5) begin
      @(posedge clk);
      #1;
      check_reset("rst_hold");
    end
    @(negedge clk);
    rst_n = 1'b1;
    n     = 0;
    fp    = 0;
    off   = 0;

    // Black first frame after reset, then a scheduled pattern.
    run_cycles(2 * FRAME + 20);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
